instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Requester side of the instruction memory interface. Drives a 64-bit byte address and samples the combinational 32-bit instruction returned in the same cycle.
- Holds the PC and advances it by 4 per fetch.
- Buffers fetched {pc, instr} pairs in a small FIFO toward decode, using a valid/ready handshake.
- Handles redirects (branch/jump) and out-of-range fetch faults.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- FQ_DEPTH, 2, fetch queue entries (power of 2, ≥2).
- IMEM_ADDR_BITS, 15, implemented instruction memory address bits; a PC with any bit at or above this index set is out of range.
- BITS, 32, instruction width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_en  in  1  allows leaving IDLE and continuing to fetch.
- imem_addr  out  64  byte address to instruction memory, equal to the PC register.
- imem_instr  in  BITS  instruction for imem_addr, valid in the same cycle.
- redirect_valid  in  1  load a new PC this cycle.
- redirect_pc  in  64  redirect target.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  BITS  head instruction.
- out_pc  out  64  head PC.
- fault  out  1  fetch halted on a bad address.
- fault_pc  out  64  PC that caused the fault.

Behaviour:
- Reset: pc=RESET_PC, queue empty, out_valid=0, out_instr=0, out_pc=0, fault=0, fault_pc=0, state=IDLE.
- State IDLE:
  - No push.
  - Moves to FETCH on the next edge when fetch_en=1.
- State FETCH, each cycle:
  - A push occurs when there is no redirect, pc is in range and aligned, and the queue is not full or the head is popped this cycle (out_valid & out_ready).
  - On a push, entry {pc, imem_instr} is enqueued and pc <= pc+4, wrapping modulo 2^64.
  - If fetch_en=0, no push; go to IDLE, pc held.
- Fault condition: pc[1:0]!=0, or pc[63:IMEM_ADDR_BITS]!=0.
  - If true in FETCH with no redirect: no push, fault<=1, fault_pc<=pc, state<=FAULT.
- State FAULT:
  - No fetch.
  - Queue still drains normally.
  - Exits only via redirect or rst.
- Redirect (any state, highest priority below rst):
  - pc <= redirect_pc.
  - Queue flushed: count=0, so out_valid=0 next cycle.
  - No push that cycle.
  - fault<=0.
  - state<=FETCH if fetch_en, else IDLE.
  - A redirect to a bad target is accepted; the fault is raised on the following FETCH cycle.
- Redirect in the same cycle as a pop: the pop is counted as accepted by decode, then the flush occurs.
- Queue:
  - Circular buffer with read/write pointers of width log2(FQ_DEPTH) and a count of width log2(FQ_DEPTH)+1.
  - out_* come directly from the head entry, registered storage with no combinational path from imem_instr.
  - Fetch-to-out_valid latency is 1 cycle.
- Full queue with no pop: pc holds and imem_addr is stable.
- Simultaneous push and pop when full: allowed, count unchanged.
- Once the queue is filled, throughput is 1 instruction/cycle with out_ready held high.
- out_instr/out_pc are don't-care while out_valid=0; the bench compares them only when valid.
- imem_addr is always pc, including in IDLE and FAULT.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_entry_t {logic [63:0] pc; logic [BITS-1:0] instr;}
  - enum fetch_state_t {IDLE, FETCH, FAULT}
  - localparam PC_STEP=4.
- Sub-module fetch_queue: parameterised FIFO of fetch_entry_t with push/pop/flush/full/empty, synchronous reset.
- The top level holds the PC, the FSM and the fault logic.

Test Plan:
- Reset then fetch_en=1, memory word k=32'h0000_0013+k, out_ready=1 → out_pc 0,4,8,12 on consecutive cycles starting 2 cycles after reset release; out_instr matches.
- out_ready=0 for 5 cycles → exactly 2 entries (pc 0,4) queued; imem_addr held at 8; release out_ready → pc 0,4,8 delivered in order with no duplicates or loss.
- Redirect to 64'h100 while the queue holds 2 entries and out_ready=1 → the head accepted that cycle is the last old entry; next cycle out_valid=0; following outputs out_pc=0x100, 0x104.
- Redirect to 64'h102 (misaligned) → one cycle later fault=1, fault_pc=0x102, no further pushes; redirect to 0x200 → fault=0, fetch resumes at 0x200.
- Sequential fetch reaching pc=0x8000 with IMEM_ADDR_BITS=15 → fault=1, fault_pc=0x8000; entry 0x7FFC still delivered.
- rst asserted mid-stream with a full queue → next cycle out_valid=0, fault=0, imem_addr=RESET_PC, state IDLE until fetch_en is sampled high.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit:
// queue entry layout, FSM states and PC step.
package fetch_pkg;

  localparam int INSTR_BITS = 32;
  localparam logic [63:0] PC_STEP = 64'd4;

  typedef struct packed {
    logic [63:0]           pc;
    logic [INSTR_BITS-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FAULT
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/response and
// fetch-to-decode valid/ready bundle.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic [63:0]           imem_addr;
  logic [INSTR_BITS-1:0] imem_instr;
  logic                  out_valid;
  logic                  out_ready;
  logic [INSTR_BITS-1:0] out_instr;
  logic [63:0]           out_pc;

  modport master (
    output imem_addr,
    input  imem_instr,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );

endinterface

// File: rtl/instr_fetch_unit_queue.sv
// Circular FIFO of {pc, instr} entries between
// fetch and decode, with single-cycle flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;

  assign dout  = mem_q[rd_q];
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + (AW+1)'(push)
                    - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push && !flush)
        mem_q[wr_q] <= din;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, fetch FSM, fault
// capture and the fetch queue toward decode.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC       = 64'h0,
  parameter int          FQ_DEPTH       = 2,
  parameter int          IMEM_ADDR_BITS = 15,
  parameter int          BITS           = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_en,
  input  logic                redirect_valid,
  input  logic [63:0]         redirect_pc,
  instr_fetch_unit_if.master  bus,
  output logic                fault,
  output logic [63:0]         fault_pc
);

  fetch_state_t state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic [63:0]  fpc_q, fpc_d;

  logic         push, pop, flush;
  logic         full, empty, bad;
  logic [BITS-1:0] instr_w;
  fetch_entry_t din, head;

  assign instr_w   = bus.imem_instr;
  assign din.pc    = pc_q;
  assign din.instr = instr_w;

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = !empty;
  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;
  assign fault         = fault_q;
  assign fault_pc      = fpc_q;

  assign pop = !empty && bus.out_ready;
  assign bad = (pc_q[1:0] != 2'b00) ||
               (pc_q[63:IMEM_ADDR_BITS] != '0);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    fpc_d   = fpc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      flush   = 1'b1;
      fault_d = 1'b0;
      state_d = fetch_en ? FETCH : IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (fetch_en) state_d = FETCH;
        FETCH: begin
          if (!fetch_en) begin
            state_d = IDLE;
          end else if (bad) begin
            fault_d = 1'b1;
            fpc_d   = pc_q;
            state_d = FAULT;
          end else if (!full || pop) begin
            push = 1'b1;
            pc_d = pc_q + PC_STEP;
          end
        end
        FAULT: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      fpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      fpc_q   <= fpc_d;
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-level model
// checked every cycle plus directed literal checks.
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        fault;
  logic [63:0] fault_pc;

  int tests = 0;
  int fails = 0;

  instr_fetch_unit_if bus();

  function automatic logic [31:0] mem(
    input logic [63:0] a
  );
    return 32'h13 + a[33:2];
  endfunction

  assign bus.imem_instr = mem(bus.imem_addr);

  instr_fetch_unit #(
    .RESET_PC       (64'h0),
    .FQ_DEPTH       (DEPTH),
    .IMEM_ADDR_BITS (15),
    .BITS           (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Model: architectural PC, mode and a queue of
  // {pc, instr} entries, stepped on each clock edge.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_pc = '0;
  logic        m_fault = 1'b0;
  logic [63:0] m_fpc = '0;
  int          m_mode = 0;
  bit          m_on = 1'b0;

  always @(posedge clk) begin
    bit   popd;
    bit   badpc;
    ent_t e;
    if (rst) begin
      m_pc = '0;
      mq.delete();
      m_fault = 1'b0;
      m_fpc = '0;
      m_mode = 0;
      m_on = 1'b1;
    end else if (m_on) begin
      popd = (mq.size() > 0) && bus.out_ready;
      badpc = (m_pc % 4 != 0) ||
              (m_pc >= 64'h8000);
      if (redirect_valid) begin
        mq.delete();
        m_pc = redirect_pc;
        m_fault = 1'b0;
        m_mode = fetch_en ? 1 : 0;
      end else begin
        if (popd) void'(mq.pop_front());
        if (m_mode == 0) begin
          if (fetch_en) m_mode = 1;
        end else if (m_mode == 1) begin
          if (!fetch_en) begin
            m_mode = 0;
          end else if (badpc) begin
            m_fault = 1'b1;
            m_fpc = m_pc;
            m_mode = 2;
          end else if (mq.size() < DEPTH) begin
            e.pc = m_pc;
            e.instr = mem(m_pc);
            mq.push_back(e);
            m_pc = m_pc + 64'd4;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("out_valid", 64'(bus.out_valid),
          64'(mq.size() != 0));
      if (mq.size() != 0 && bus.out_valid) begin
        chk("out_pc", bus.out_pc, mq[0].pc);
        chk("out_instr", 64'(bus.out_instr),
            64'(mq[0].instr));
      end
      chk("fault", 64'(fault), 64'(m_fault));
      chk("fault_pc", fault_pc, m_fpc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_addr", bus.imem_addr, 64'h0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_fpc", fault_pc, 64'h0);
    chk("rst_opc", bus.out_pc, 64'h0);
    chk("rst_oinstr", 64'(bus.out_instr), 64'h0);
    rst = 1'b0;
  endtask

  task automatic redir(input logic [63:0] t);
    redirect_valid = 1'b1;
    redirect_pc = t;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    bus.out_ready = 1'b0;
    ticks(1);
    // streaming from reset
    do_reset();
    fetch_en = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("s_lat", 64'(bus.out_valid), 64'd0);
    tick();
    chk("s_pc0", bus.out_pc, 64'h0);
    chk("s_in0", 64'(bus.out_instr), 64'h13);
    tick();
    chk("s_pc4", bus.out_pc, 64'h4);
    chk("s_in4", 64'(bus.out_instr), 64'h14);
    tick();
    chk("s_pc8", bus.out_pc, 64'h8);
    tick();
    chk("s_pc12", bus.out_pc, 64'hc);
    chk("s_in12", 64'(bus.out_instr), 64'h16);

    // backpressure fills the queue
    do_reset();
    bus.out_ready = 1'b0;
    ticks(6);
    chk("bp_addr", bus.imem_addr, 64'h8);
    chk("bp_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_head", bus.out_pc, 64'h0);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_pc4", bus.out_pc, 64'h4);
    tick();
    chk("bp_pc8", bus.out_pc, 64'h8);

    // redirect while full, head 8 accepted
    redir(64'h100);
    chk("rd_flush", 64'(bus.out_valid), 64'd0);
    chk("rd_addr", bus.imem_addr, 64'h100);
    tick();
    chk("rd_pc100", bus.out_pc, 64'h100);
    chk("rd_in100", 64'(bus.out_instr), 64'h53);
    tick();
    chk("rd_pc104", bus.out_pc, 64'h104);

    // misaligned target
    redir(64'h102);
    chk("ma_nofault", 64'(fault), 64'd0);
    tick();
    chk("ma_fault", 64'(fault), 64'd1);
    chk("ma_fpc", fault_pc, 64'h102);
    ticks(3);
    chk("ma_hold", bus.imem_addr, 64'h102);
    chk("ma_novalid", 64'(bus.out_valid), 64'd0);
    redir(64'h200);
    chk("ma_clear", 64'(fault), 64'd0);
    tick();
    chk("ma_pc200", bus.out_pc, 64'h200);

    // running off the end of memory
    redir(64'h7ff0);
    ticks(4);
    chk("oor_last", bus.out_pc, 64'h7ffc);
    tick();
    chk("oor_fault", 64'(fault), 64'd1);
    chk("oor_fpc", fault_pc, 64'h8000);

    // reset with a full queue
    bus.out_ready = 1'b0;
    redir(64'h40);
    ticks(3);
    chk("fr_addr", bus.imem_addr, 64'h48);
    chk("fr_head", bus.out_pc, 64'h40);
    rst = 1'b1;
    tick();
    chk("fr_valid", 64'(bus.out_valid), 64'd0);
    chk("fr_addr0", bus.imem_addr, 64'h0);
    rst = 1'b0;
    fetch_en = 1'b0;
    ticks(3);
    chk("fr_idle", 64'(bus.out_valid), 64'd0);
    fetch_en = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("fr_lat", 64'(bus.out_valid), 64'd0);
    tick();
    chk("fr_pc0", bus.out_pc, 64'h0);

    // fetch_en drop parks the PC
    fetch_en = 1'b0;
    ticks(2);
    chk("fe_addr", bus.imem_addr, 64'h4);
    chk("fe_valid", 64'(bus.out_valid), 64'd0);
    ticks(2);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
